// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-memory cacheline arbiter: FSM states, requester
// identities and default widths.
package arbiter_types;
    localparam int LINE_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic       {SRC_I, SRC_D}           arb_src_t;
endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter granting the single cacheline memory port to either the
// icache or the dcache, one full line transaction at a time.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    arb_src_t          last_grant_q, last_grant_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LINE_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              i_pend, d_pend;
    arb_src_t          pick;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        if (i_pend && !d_pend)      pick = SRC_I;
        else if (!i_pend && d_pend) pick = SRC_D;
        else if (last_grant_q == SRC_D) pick = SRC_I;
        else                        pick = SRC_D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_D;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    last_grant_d = pick;
                    if (pick == SRC_I) begin
                        state_d     = SERVE_I;
                        cmd_write_d = 1'b0;
                        cmd_addr_d  = i_address;
                    end else begin
                        // An illegal read+write collision is served as the write.
                        state_d     = SERVE_D;
                        cmd_write_d = d_write;
                        cmd_addr_d  = d_address;
                        cmd_wdata_d = d_wdata;
                    end
                end
            end
            SERVE_I: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                mem_read  = ~cmd_write_q;
                mem_write = cmd_write_q;
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_address = cmd_addr_q;
    assign mem_wdata   = cmd_wdata_q;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        assert (!(rst && d_read && d_write));
    end
`endif

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single cacheline memory port between the instruction cache (read-only misses driven by the fetch path) and the data cache (load/store misses and write-backs). Sits between the two L1 caches and the cacheline adaptor in the core's memory hierarchy. Serves one full 256-bit line transaction at a time to completion. Uses round-robin on simultaneous requests so neither fetch nor memory operations starve.

## Interface
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, line address width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset; block is held in reset while rst=0
- i_read  in  1  icache line read request, held until i_resp
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line returned to icache
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line write-back request, held until d_resp
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  write-back line
- d_rdata  out  LINE_W  line returned to dcache
- d_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  read command to cacheline adaptor
- mem_write  out  1  write command to cacheline adaptor
- mem_address  out  ADDR_W  command address
- mem_wdata  out  LINE_W  write data
- mem_rdata  in  LINE_W  returned line
- mem_resp  in  1  adaptor completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: no mem command.
  - Only i_read pending: go to SERVE_I.
  - Only d_read or d_write pending: go to SERVE_D.
  - Both pending: grant the side not in last_grant.
- At grant, register the granted side's command type, address and wdata into cmd_* registers.
  - mem_* outputs are driven only from cmd_* registers, never combinationally from requesters.
  - Update last_grant.
- SERVE_I: mem_read=1, mem_address=cmd_addr until mem_resp. On mem_resp: i_resp=1 that cycle; next state IDLE.
- SERVE_D: mem_read or mem_write=1 per captured type until mem_resp. On mem_resp: d_resp=1; next state IDLE.
- i_rdata and d_rdata are both wired to mem_rdata. Only the resp pulses are gated by state.
- d_read and d_write high together is illegal. The write is served and a simulation assertion fires.
- A request dropped mid-service does not abort the memory transaction; it completes and resp still pulses.
- mem_resp in IDLE is ignored: no resp pulse, no state change.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=D, so the icache wins the first tie.
  - All mem_* commands, i_resp and d_resp = 0; cmd_addr and cmd_wdata = 0.
- Reset mid-transaction: the command is dropped immediately and no resp is issued. Adaptor reset is the system's responsibility.
- Grant latency: request sampled high in IDLE at edge N → mem command visible in cycle N+1.
- Completion: resp is combinational with mem_resp in the same cycle. The arbiter is in IDLE the following cycle.
- Requesters must deassert in the cycle after their resp. The arbiter re-samples requests in that IDLE cycle, so a requester still high is re-granted as a new transaction.
- Minimum turnaround: one IDLE cycle between consecutive transactions. Back-to-back service takes mem latency + 2 cycles per line.
- Alternation: with both sides permanently requesting, grants strictly alternate I, D, I, D….
- Commands stay stable (address, wdata, type) for the whole SERVE_* state, independent of requester input changes.

## Structure
- Shared package (arbiter_types, alongside rv32i_types):
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D}
  - enum arb_src_t {SRC_I, SRC_D}
  - LINE_W default constant
- Single module; no sub-module needed. Round-robin pick is a few lines of combinational logic.

## Test plan
- Icache read only: i_read=1, i_address=0x0000_0060; adaptor responds after 5 cycles with line 0xA5…A5 → mem_read one cycle after request, mem_address=0x60, i_resp pulse with i_rdata=0xA5…A5, no d_resp.
- Simultaneous first requests after reset: i_read and d_read at 0x100 / 0x200 → icache served first (0x100), then after one IDLE cycle dcache (0x200).
- Sustained contention over 6 transactions → grant order I,D,I,D,I,D; each resp lands on the correct side.
- Write-back: d_write=1, d_address=0x0000_0400, d_wdata=0xDEAD…BEEF; d_wdata changed mid-service → mem_write=1 with captured 0xDEAD…BEEF held stable until mem_resp; d_resp pulses.
- Reset asserted (rst=0) during SERVE_D → all mem_* and resp outputs 0 immediately. After release with only i_read pending, the icache is granted.
- Spurious mem_resp in IDLE → no i_resp/d_resp, state remains IDLE.
